// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals exchanged with the hazard/stall controller
interface hazard_ctrl_if;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_hold;
  logic [1:0]  state_o;
  modport master (
    output id_instr, id_valid, ex_valid, ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, state_o
  );
  modport slave (
    input  id_instr, id_valid, ex_valid, ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, state_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and memory-wait freeze sequencer for the front end
// Optional HAZARD_CTRL_PERF_EN adds 32-bit ldstall/redirect/memwait cycle counters.
module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave p
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] ldstall_cnt,
  output logic [31:0] redirect_cnt,
  output logic [31:0] memwait_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MEMWAIT = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       ret_ld_q, ret_ld_d;
  logic       rs1_used, rs2_used, hazard, memwait, redirect;
  logic       hold, flush, stall;
  logic [6:0] opc;
  logic       unused_bits;
  assign opc = p.id_instr[6:0];
  assign unused_bits = ^{p.id_instr[31:25], p.id_instr[14:7]};
  assign rs1_used = opc inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                7'b1100011, 7'b0110011, 7'b0011011, 7'b0111011};
  assign rs2_used = opc inside {7'b0100011, 7'b1100011, 7'b0110011, 7'b0111011};
  assign hazard = p.id_valid & p.ex_valid & p.ex_mem_read & (p.ex_rd != 5'd0) &
                  ((rs1_used & (p.id_instr[19:15] == p.ex_rd)) |
                   (rs2_used & (p.id_instr[24:20] == p.ex_rd)));
  assign memwait  = p.mem_req & ~p.mem_ready;
  assign redirect = p.ex_redirect & p.ex_valid;
  assign hold  = rst_n & memwait;
  assign flush = rst_n & ~memwait & redirect;
  assign p.pc_write     = rst_n & ~hold & ~stall;
  assign p.if_id_write  = rst_n & ~hold & ~stall;
  assign p.if_id_flush  = ~rst_n | flush;
  assign p.id_ex_bubble = ~rst_n | flush | stall;
  assign p.pipe_hold    = hold;
  assign p.state_o      = rst_n ? state_q : RUN;
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    ret_ld_d = ret_ld_q;
    stall    = 1'b0;
    if (!rst_n || hold) begin
      state_d  = hold ? MEMWAIT : state_q;
      ret_ld_d = hold ? ((state_q == MEMWAIT) ? ret_ld_q : (state_q == LDSTALL)) : ret_ld_q;
    end else if (flush) begin
      state_d  = RUN;
      lu_cnt_d = 2'd0;
      ret_ld_d = 1'b0;
    end else if (state_q == LDSTALL) begin
      stall    = 1'b1;
      state_d  = (lu_cnt_q == 2'd0) ? RUN : LDSTALL;
      lu_cnt_d = (lu_cnt_q == 2'd0) ? 2'd0 : lu_cnt_q - 2'd1;
    end else if (state_q == MEMWAIT && ret_ld_q) begin
      // resume the interrupted load-use stall with its count intact
      state_d  = LDSTALL;
      ret_ld_d = 1'b0;
    end else begin
      stall    = hazard;
      ret_ld_d = 1'b0;
      state_d  = (hazard && LU_STALL_CYCLES > 1) ? LDSTALL : RUN;
      lu_cnt_d = (hazard && LU_STALL_CYCLES > 1) ? 2'(LU_STALL_CYCLES - 2) : 2'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
      ret_ld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      ret_ld_q <= ret_ld_d;
    end
  end
`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ldstall_cnt  <= 32'd0;
      redirect_cnt <= 32'd0;
      memwait_cnt  <= 32'd0;
    end else begin
      ldstall_cnt  <= ldstall_cnt + {31'd0, stall};
      redirect_cnt <= redirect_cnt + {31'd0, flush};
      memwait_cnt  <= memwait_cnt + {31'd0, hold};
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random and directed stimulus on LU=1 and LU=3 controllers against a stall-budget model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hazard_ctrl_if a ();
  hazard_ctrl_if b ();
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] lc [2];
  logic [31:0] rc [2];
  logic [31:0] mc [2];
`endif
  hazard_ctrl #(.LU_STALL_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .p(a.slave)
`ifdef HAZARD_CTRL_PERF_EN
    , .ldstall_cnt(lc[0]), .redirect_cnt(rc[0]), .memwait_cnt(mc[0])
`endif
  );
  hazard_ctrl #(.LU_STALL_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .p(b.slave)
`ifdef HAZARD_CTRL_PERF_EN
    , .ldstall_cnt(lc[1]), .redirect_cnt(rc[1]), .memwait_cnt(mc[1])
`endif
  );
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  logic [31:0] instr;
  logic [4:0]  rd;
  bit idv, exv, mr, redir, mreq, mrdy;
  // model: bubbles still owed, and whether a memory wait is pausing them
  int lu [2] = '{1, 3};
  int left [2];
  bit wt [2];
  int c_ld [2], c_rd [2], c_mw [2];
  function automatic bit hz();
    logic [6:0] o = instr[6:0];
    bit u1 = o inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33, 7'h1b, 7'h3b};
    bit u2 = o inside {7'h23, 7'h63, 7'h33, 7'h3b};
    return idv && exv && mr && rd != 0 &&
           ((u1 && instr[19:15] == rd) || (u2 && instr[24:20] == rd));
  endfunction
  task automatic step();
    logic [6:0] e, got;
    logic [1:0] st;
    a.id_instr = instr; a.id_valid = idv; a.ex_valid = exv; a.ex_mem_read = mr;
    a.ex_rd = rd; a.ex_redirect = redir; a.mem_req = mreq; a.mem_ready = mrdy;
    b.id_instr = instr; b.id_valid = idv; b.ex_valid = exv; b.ex_mem_read = mr;
    b.ex_rd = rd; b.ex_redirect = redir; b.mem_req = mreq; b.mem_ready = mrdy;
    #1;
    for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_CTRL_PERF_EN
      check("ldstall_cnt", lc[k], c_ld[k]);
      check("redirect_cnt", rc[k], c_rd[k]);
      check("memwait_cnt", mc[k], c_mw[k]);
`endif
      st = wt[k] ? 2'd2 : (left[k] > 0 ? 2'd1 : 2'd0);
      if (!rst_n) begin
        e = 7'b0011000; left[k] = 0; wt[k] = 0; c_ld[k] = 0; c_rd[k] = 0; c_mw[k] = 0;
      end else if (mreq && !mrdy) begin
        e = {5'b00001, st}; wt[k] = 1; c_mw[k]++;
      end else if (redir && exv) begin
        e = {5'b11110, st}; left[k] = 0; wt[k] = 0; c_rd[k]++;
      end else if (left[k] > 0 && !wt[k]) begin
        e = {5'b00010, st}; left[k]--; c_ld[k]++;
      end else if (left[k] > 0) begin
        e = {5'b11000, st}; wt[k] = 0;
      end else begin
        wt[k] = 0;
        if (hz()) begin e = {5'b00010, st}; left[k] = lu[k] - 1; c_ld[k]++; end
        else e = {5'b11000, st};
      end
      got = k == 0 ? {a.pc_write, a.if_id_write, a.if_id_flush, a.id_ex_bubble, a.pipe_hold, a.state_o}
                   : {b.pc_write, b.if_id_write, b.if_id_flush, b.id_ex_bubble, b.pipe_hold, b.state_o};
      check(k == 0 ? "ctrl_lu1" : "ctrl_lu3", {25'd0, got}, {25'd0, e});
    end
    @(negedge clk);
  endtask
  task automatic cyc(input logic [31:0] i_, input bit v_, input bit ev_, input bit mr_,
                     input logic [4:0] rd_, input bit rr_, input bit mq_, input bit my_, input int n);
    instr = i_; idv = v_; exv = ev_; mr = mr_; rd = rd_; redir = rr_; mreq = mq_; mrdy = my_;
    repeat (n) step();
  endtask
  localparam logic [31:0] ADD = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] LUI = {20'h12345, 5'd6, 7'b0110111};
  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17, 7'h6f};
  initial begin
    @(negedge clk);
    rst_n = 0;
    cyc(ADD, 1, 1, 1, 5, 0, 0, 0, 2);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(ADD, 1, 1, 1, 5, 0, 0, 0, 4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);
    cyc(LUI, 1, 1, 1, 5, 0, 0, 0, 2);
    cyc(ADD, 1, 1, 1, 0, 0, 0, 0, 2);
    cyc(ADD, 1, 1, 1, 5, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(ADD, 1, 1, 1, 5, 0, 0, 0, 1);
    cyc(ADD, 1, 1, 1, 5, 0, 1, 0, 4);
    cyc(ADD, 1, 1, 1, 5, 0, 1, 1, 1);
    cyc(ADD, 1, 1, 1, 5, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);
    cyc(ADD, 1, 1, 1, 5, 0, 0, 0, 1);
    cyc(ADD, 1, 1, 1, 5, 0, 1, 0, 2);
    rst_n = 0;
    cyc(ADD, 1, 1, 1, 5, 0, 1, 0, 1);
    rst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r = $urandom;
      r[6:0] = ops[$urandom_range(0, 10)];
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      rst_n = $urandom_range(0, 99) != 0;
      cyc(r, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 1) == 0, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV64I core. Sits beside the IF/ID and ID/EX registers, decodes the register-use pattern of the instruction in ID from its opcode, and sequences stalls, bubbles, flushes and memory-wait freezes. It owns every pipeline-register write-enable and flush in the front end. Branch and jump redirects are resolved in EX.

## Interface
Parameters:
- LU_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_instr  in  32  instruction held in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_valid  in  1  ID/EX holds a real instruction.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- mem_req  in  1  MEM stage has a data-memory access in flight.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC write enable.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID load-NOP.
- id_ex_bubble  out  1  ID/EX load-NOP.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- state_o  out  2  current FSM state, for debug.

## Operation
- rs1 is used for opcodes 0010011, 0000011, 1100111, 0100011, 1100011, 0110011, 0011011 and 0111011.
- rs2 is used for opcodes 0100011, 1100011, 0110011 and 0111011.
- U-type and J-type opcodes use no source registers. x0 never creates a hazard.
- hazard = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- memwait = mem_req & !mem_ready.
- FSM states: RUN=0, LDSTALL=1, MEMWAIT=2. A 2-bit counter lu_cnt and a 1-bit register ret_ld track return state.
- Default outputs (nothing pending): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
- Priority within a cycle is memwait, then redirect, then hazard.
- memwait, from any state:
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1, flush=0, bubble=0.
  - Transition: next state MEMWAIT; ret_ld records whether the FSM was in LDSTALL; lu_cnt frozen.
- MEMWAIT with mem_ready=1: default outputs, then the FSM returns to LDSTALL if ret_ld, else RUN. A hazard or redirect in that cycle is evaluated as in RUN.
- Redirect (ex_redirect & ex_valid, no memwait):
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Transition: next state RUN; lu_cnt cleared. This aborts any LDSTALL, because the stalled instruction is wrong-path.
- Hazard in RUN (no memwait, no redirect):
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1. This cycle is bubble #1.
  - Transition: if LU_STALL_CYCLES>1, go to LDSTALL with lu_cnt=LU_STALL_CYCLES-2; otherwise stay in RUN.
- LDSTALL: same stall outputs; hazard detection is ignored. If lu_cnt==0, next state is RUN; otherwise lu_cnt decrements.

## Timing
- All outputs are combinational (Mealy) from the state and the current-cycle inputs; zero-cycle latency from hazard or redirect to the control signals.
- A load-use hazard costs exactly LU_STALL_CYCLES cycles, plus any memwait cycles.
- A redirect costs exactly one flush cycle; the target is fetched in the next cycle.
- Reset: while rst_n=0 at a clock edge, state←RUN, lu_cnt←0, ret_ld←0.
- Outputs while rst_n=0:
  - pc_write=0, if_id_write=0, pipe_hold=0.
  - if_id_flush=1, id_ex_bubble=1, state_o=0.
- Reset has immediate effect in any state, including mid-LDSTALL or mid-MEMWAIT.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - Adds outputs ldstall_cnt, redirect_cnt and memwait_cnt, each 32 bits.
  - Each counter increments once per cycle of the corresponding stall or flush; all wrap at 2^32 and clear on reset.
- HAZARD_CTRL_PERF_EN undefined: these ports and registers do not exist.

## Test plan
- `lw x5` in EX, `add x6,x5,x7` in ID, LU_STALL_CYCLES=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, state_o=0; default outputs next cycle.
- LU_STALL_CYCLES=3, same pair → three stall cycles with state_o sequence 0,1,1, then RUN; `lui x6` or `lw x0` in the same positions → no stall.
- ex_redirect=1 in the same cycle as a hazard → if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall; state RUN.
- Cycle 2 of an LDSTALL (LU_STALL_CYCLES=3) with mem_req=1, mem_ready=0 for 4 cycles → pipe_hold=1 for 4 cycles; then state_o returns to 1 with lu_cnt unchanged and the remaining stall cycle completes.
- rst_n=0 asserted during MEMWAIT → next state_o=0; reset-value outputs while low; default outputs after release.
- With HAZARD_CTRL_PERF_EN: 2 load-use hazards (LU=1), 1 redirect and 3 memwait cycles → ldstall_cnt=2, redirect_cnt=1, memwait_cnt=3.
